// File: rtl/apb_completer_pkg.sv
// Shared types for the APB register completer.
// State encoding, register indices and the decode bundle.
package apb_completer_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int IDX_W = 8;

    localparam logic [IDX_W-1:0] REG_ID     = 8'd0;
    localparam logic [IDX_W-1:0] REG_STATUS = 8'd1;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA11C_0001;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic             is_read_only;
        logic             err;
    } dec_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB address decode.
// Flags misaligned, unmapped and read-only-write accesses.
module apb_addr_decode
    import apb_completer_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_REGS   = 8
) (
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    output dec_t                  dec
);

    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(4 * NUM_REGS);

    logic             misaligned;
    logic             out_of_range;
    logic [IDX_W-1:0] index;
    logic             read_only;

    assign misaligned   = |paddr[1:0];
    assign out_of_range = {1'b0, paddr} >= LIMIT;
    assign index        = IDX_W'(paddr >> 2);
    assign read_only    = (index == REG_ID) || (index == REG_STATUS);

    assign dec.index        = index;
    assign dec.is_read_only = read_only;
    assign dec.err          = misaligned | out_of_range
                            | (pwrite & read_only);

endmodule

// File: rtl/apb_regs_completer.sv
// APB completer with wait states exposing a small register file.
// Reg 0 is a fixed ID, reg 1 reads core status, the rest are RW.
module apb_regs_completer
    import apb_completer_pkg::*;
#(
    parameter int                   ADDR_WIDTH  = 16,
    parameter int                   DATA_WIDTH  = 32,
    parameter int                   NUM_REGS    = 8,
    parameter int                   WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = ID_VALUE_DEFAULT
) (
    input  logic                           clk,
    input  logic                           preset,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic                           pwrite,
    input  logic                           psel,
    input  logic                           penable,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    input  logic [DATA_WIDTH-1:0]          status_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int          RW = $clog2(NUM_REGS);
    localparam logic [3:0]  WS = 4'(WAIT_STATES);

    state_t                state;
    state_t                state_nx;
    logic [3:0]            cnt;
    dec_t                  dec;
    dec_t                  dec_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] status_q;
    logic [DATA_WIDTH-1:0] rw_regs [NUM_REGS];
    logic                  setup;
    logic                  commit;
    logic [RW-1:0]         ridx;

    apb_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_decode (
        .paddr  (paddr),
        .pwrite (pwrite),
        .dec    (dec)
    );

    assign setup  = (state == IDLE) && psel && !penable;
    assign ridx   = dec_q.index[RW-1:0];
    assign commit = pready && wr_q && !dec_q.err && !dec_q.is_read_only;

    always_ff @(posedge clk) begin
        if (preset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (setup) state_nx = ACCESS;
            ACCESS: if (!psel || pready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs depend only on latched decode plus the handshake strobes.
    always_comb begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        if (state == ACCESS && psel && penable && cnt == WS) begin
            pready  = 1'b1;
            pslverr = dec_q.err;
            if (!wr_q && !dec_q.err) begin
                unique case (1'b1)
                    (dec_q.index == REG_ID):     prdata = ID_VALUE;
                    (dec_q.index == REG_STATUS): prdata = status_q;
                    default:                     prdata = rw_regs[ridx];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (preset) begin
            cnt        <= '0;
            dec_q      <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            status_q   <= '0;
            wr_pulse_o <= '0;
            for (int i = 0; i < NUM_REGS; i++) rw_regs[i] <= '0;
        end else begin
            wr_pulse_o <= '0;
            if (setup) begin
                cnt      <= '0;
                dec_q    <= dec;
                wr_q     <= pwrite;
                wdata_q  <= pwdata;
                status_q <= status_i;
            end else if (state == ACCESS && psel && penable && cnt != WS) begin
                cnt <= cnt + 4'd1;
            end
            if (commit) begin
                rw_regs[ridx]    <= wdata_q;
                wr_pulse_o[ridx] <= 1'b1;
            end
        end
    end

    for (genvar n = 0; n < NUM_REGS; n++) begin : g_regs
        if (n == 0) begin : g_id
            assign regs_o[n*DATA_WIDTH +: DATA_WIDTH] = ID_VALUE;
        end else if (n == 1) begin : g_status
            assign regs_o[n*DATA_WIDTH +: DATA_WIDTH] = status_i;
        end else begin : g_rw
            assign regs_o[n*DATA_WIDTH +: DATA_WIDTH] = rw_regs[n];
        end
    end

endmodule

// File: tb/tb_apb_regs_completer.sv
// Bench for apb_regs_completer: randomized APB traffic, scoreboard
// checked by a monitor, plus a zero-wait-state back-to-back instance.
module tb_apb_regs_completer;

    localparam int WS = 1;
    localparam int NR = 8;
    localparam logic [31:0] ID = 32'hA11C_0001;

    logic        clk = 1'b0;
    logic        preset;
    logic [15:0] paddr;
    logic        pwrite, psel, penable;
    logic [31:0] pwdata, prdata, status_i;
    logic        pready, pslverr;
    logic [NR*32-1:0] regs_o;
    logic [NR-1:0]    wr_pulse_o;

    logic        b_preset;
    logic [15:0] b_paddr;
    logic        b_pwrite, b_psel, b_penable;
    logic [31:0] b_pwdata, b_prdata, b_status_i;
    logic        b_pready, b_pslverr;
    logic [NR*32-1:0] b_regs_o;
    logic [NR-1:0]    b_wr_pulse_o;

    always #5 clk = ~clk;

    apb_regs_completer #(.WAIT_STATES(WS)) u_dut (
        .clk(clk), .preset(preset), .paddr(paddr), .pwrite(pwrite),
        .psel(psel), .penable(penable), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .status_i(status_i), .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    apb_regs_completer #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .preset(b_preset), .paddr(b_paddr), .pwrite(b_pwrite),
        .psel(b_psel), .penable(b_penable), .pwdata(b_pwdata),
        .pready(b_pready), .prdata(b_prdata), .pslverr(b_pslverr),
        .status_i(b_status_i), .regs_o(b_regs_o), .wr_pulse_o(b_wr_pulse_o)
    );

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          wr;
        int          idx;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mregs [NR];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the access outcome follows directly from the address map.
    task automatic xfer(input logic [15:0] a, input bit w,
                        input logic [31:0] d, input logic [31:0] st);
        exp_t e;
        int   g;
        e.idx   = int'(a) / 4;
        e.err   = (a % 4 != 0) || (int'(a) >= 4 * NR) || (w && int'(a) < 8);
        e.wr    = w;
        e.wdata = d;
        if (w || e.err)     e.rdata = '0;
        else if (e.idx == 0) e.rdata = ID;
        else if (e.idx == 1) e.rdata = st;
        else                 e.rdata = mregs[e.idx];
        sb.push_back(e);
        psel = 1'b1; penable = 1'b0;
        paddr = a; pwrite = w; pwdata = d; status_i = st;
        step();
        penable  = 1'b1;
        status_i = ~st;
        pwdata   = ~d;
        paddr    = a ^ 16'h0004;
        #1;
        g = 0;
        while (!pready && g < 20) begin
            @(posedge clk);
            #2;
            g++;
        end
        if (g >= 20) chk("xfer_timeout", 64'(g), 64'(WS));
        step();
    endtask

    task automatic idle(input int n);
        psel = 1'b0; penable = 1'b0;
        repeat (n) step();
    endtask

    task automatic abort_xfer(input logic [15:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = 1'b1; pwdata = d;
        step();
        psel = 1'b0;
        step();
    endtask

    task automatic reset_mid(input logic [15:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = 1'b1; pwdata = d;
        step();
        penable = 1'b1;
        preset  = 1'b1;
        step();
        preset = 1'b0;
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        step();
    endtask

    logic [NR-1:0] pulse_due = '0;
    bit            regs_chk  = 1'b0;
    int            acc       = 0;

    always @(negedge clk) begin
        exp_t e;
        if (preset) begin
            pulse_due = '0;
            regs_chk  = 1'b0;
            acc       = 0;
        end else begin
            chk("wr_pulse", 64'(wr_pulse_o), 64'(pulse_due));
            pulse_due = '0;
            if (regs_chk) begin
                for (int i = 2; i < NR; i++)
                    chk("regs_o", 64'(regs_o[i*32 +: 32]), 64'(mregs[i]));
                regs_chk = 1'b0;
            end
            if (psel && !penable)     acc = 0;
            else if (psel && penable) acc++;
            if (pready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pready", 64'(pready), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("prdata", 64'(prdata), 64'(e.rdata));
                    chk("pslverr", 64'(pslverr), 64'(e.err));
                    chk("access_cycles", 64'(acc), 64'(WS + 1));
                    if (e.wr && !e.err) begin
                        mregs[e.idx] = e.wdata;
                        pulse_due    = NR'(1) << e.idx;
                        regs_chk     = 1'b1;
                    end
                end
            end else begin
                chk("idle_outs", {31'd0, pslverr, prdata}, 64'd0);
            end
        end
    end

    initial begin
        logic [15:0] a;
        int          r;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; status_i = '0;
        b_preset = 1'b1; b_psel = 1'b0; b_penable = 1'b0; b_pwrite = 1'b0;
        b_paddr = '0; b_pwdata = '0; b_status_i = 32'h0000_0042;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        repeat (3) step();
        preset = 1'b0; b_preset = 1'b0;
        chk("rst_pready", 64'(pready), 64'd0);
        chk("rst_prdata", 64'(prdata), 64'd0);
        chk("rst_pslverr", 64'(pslverr), 64'd0);
        chk("rst_pulse", 64'(wr_pulse_o), 64'd0);
        chk("rst_reg0", 64'(regs_o[31:0]), 64'(ID));
        chk("rst_reg2", 64'(regs_o[95:64]), 64'd0);
        step();

        xfer(16'h0, 1'b0, 32'h0, 32'h0);
        idle(1);
        xfer(16'h8, 1'b1, 32'hDEAD_BEEF, 32'h0);
        xfer(16'h8, 1'b0, 32'h0, 32'h0);
        idle(1);
        chk("reg2_slice", 64'(regs_o[95:64]), 64'h0000_0000_DEAD_BEEF);
        xfer(16'h4, 1'b1, 32'h1234, 32'h0);
        xfer(16'h22, 1'b0, 32'h0, 32'h0);
        xfer(16'h20, 1'b0, 32'h0, 32'h0);
        xfer(16'h4, 1'b0, 32'h0, 32'h0000_00A5);
        xfer(16'hC, 1'b1, 32'hCAFE_F00D, 32'h0);
        xfer(16'hC, 1'b0, 32'h0, 32'h0);
        idle(1);
        abort_xfer(16'h10, 32'h1111_1111);
        reset_mid(16'h14, 32'h2222_2222);
        xfer(16'h10, 1'b0, 32'h0, 32'h0);
        xfer(16'h14, 1'b0, 32'h0, 32'h0);
        xfer(16'h8, 1'b0, 32'h0, 32'h0);
        idle(1);

        for (int k = 0; k < 120; k++) begin
            r = $urandom_range(0, 11);
            if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 40));
            else                           a = 16'(4 * $urandom_range(0, 9));
            if (r == 0) begin
                abort_xfer(a, $urandom);
            end else if (r == 1) begin
                idle(1);
                psel = 1'b1; penable = 1'b1; paddr = a;
                step();
                idle(1);
            end else if (r == 2) begin
                idle($urandom_range(1, 3));
            end else begin
                xfer(a, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
        end
        idle(4);
        chk("sb_drain", 64'(sb.size()), 64'd0);

        b_psel = 1'b1; b_pwrite = 1'b1; b_paddr = 16'hC;
        b_pwdata = 32'h5A5A_1234;
        step();
        b_penable = 1'b1;
        #1;
        chk("b2b_wr_rdy", 64'(b_pready), 64'd1);
        chk("b2b_wr_err", 64'(b_pslverr), 64'd0);
        step();
        b_pwrite = 1'b0; b_penable = 1'b0; b_pwdata = '0;
        #1;
        chk("b2b_pulse", 64'(b_wr_pulse_o), 64'h08);
        chk("b2b_reg3", 64'(b_regs_o[3*32 +: 32]), 64'h5A5A_1234);
        step();
        chk("b2b_pulse_end", 64'(b_wr_pulse_o), 64'd0);
        b_penable = 1'b1;
        #1;
        chk("b2b_rd_rdy", 64'(b_pready), 64'd1);
        chk("b2b_rd_data", 64'(b_prdata), 64'h5A5A_1234);
        chk("b2b_rd_err", 64'(b_pslverr), 64'd0);
        step();
        b_psel = 1'b0; b_penable = 1'b0;
        #1;
        chk("b2b_done", 64'(b_pready), 64'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/apb_regs_completer.md
# apb_regs_completer

APB completer (slave) terminating the APB bus driven by the test environment's requester agent and exposing a small control/status register file to the aligner core. Decodes word-aligned addresses, inserts a programmable number of wait states, returns read data, and flags unmapped, misaligned or read-only-write accesses with `pslverr`. Register contents and per-register write strobes go to core logic.

## Interface
- `ADDR_WIDTH`, 16, width of `paddr`.
- `DATA_WIDTH`, 32, width of `pwdata`/`prdata`/registers.
- `NUM_REGS`, 8, number of 32-bit word registers (≥3), byte offsets 0x0..4*(NUM_REGS-1).
- `WAIT_STATES`, 1, access-phase cycles with `pready`=0 before completion (0..15).
- `ID_VALUE`, 32'hA11C_0001, constant returned by register 0.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `preset`  in  1  synchronous, active-high reset.
- `paddr`  in  ADDR_WIDTH  byte address.
- `pwrite`  in  1  1=write, 0=read.
- `psel`  in  1  completer select.
- `penable`  in  1  access phase.
- `pwdata`  in  DATA_WIDTH  write data.
- `pready`  out  1  transfer completes this cycle.
- `prdata`  out  DATA_WIDTH  read data, valid only when `pready`=1 and read.
- `pslverr`  out  1  error response, valid only when `pready`=1.
- `status_i`  in  DATA_WIDTH  core status, read through register 1.
- `regs_o`  out  NUM_REGS*DATA_WIDTH  flattened register contents, reg n at bits [n*DW +: DW].
- `wr_pulse_o`  out  NUM_REGS  one-cycle pulse on committed write to reg n.

## Operation
- Map: reg 0 = ID (RO, `ID_VALUE`); reg 1 = STATUS (RO, `status_i`); regs 2..NUM_REGS-1 = RW, reset 0. `regs_o` slices 0/1 carry ID/status values.
- Error if `paddr[1:0]`≠0, `paddr` ≥ 4*NUM_REGS, or write to reg 0/1. Errored writes leave registers and `wr_pulse_o` unchanged; errored reads return `prdata`=0.
- FSM states IDLE, ACCESS:
  - IDLE: `psel`=1 and `penable`=0 (setup) → latch addr, write flag, decode result, wdata; clear wait counter; → ACCESS.
  - ACCESS, `psel`=1, `penable`=1: counter < WAIT_STATES → increment, stay; counter == WAIT_STATES → completion cycle, → IDLE.
  - ACCESS, `psel`=0: abort, no commit, → IDLE.
- Back-to-back: a setup phase in the cycle following completion is accepted from IDLE normally.
- `status_i` sampled at the setup edge (read-data value reflects setup cycle).
- `psel`=1 with `penable`=1 while IDLE (protocol violation): ignored, stays IDLE, `pready`=0.

## Timing
- Reset: state IDLE, counter 0, regs 2.. = 0, `pready`=0, `prdata`=0, `pslverr`=0, `wr_pulse_o`=0.
- `pready`, `prdata`, `pslverr` decoded from registered state/counter/latched decode only (no combinational path from `paddr`/`pwdata`); all three 0 outside the completion cycle.
- Transfer length: setup + (WAIT_STATES+1) access cycles; WAIT_STATES=0 gives the minimum 2-cycle APB transfer.
- Write commit at the rising edge ending the completion cycle; register value and `wr_pulse_o` visible the following cycle, pulse lasts exactly one cycle.
- `preset` during ACCESS: transfer dropped, no commit, outputs to reset values next cycle.

## Structure
- Package `apb_completer_pkg`: state enum (IDLE, ACCESS), register indices (REG_ID=0, REG_STATUS=1), default `ID_VALUE`, decode-result struct {index, is_read_only, err}.
- Sub-module `apb_addr_decode`: combinational paddr/pwrite → decode-result struct; latched by the FSM at setup.

## Test plan
- Reset then read 0x0 with WAIT_STATES=1 → `pready` high on 2nd access cycle, `prdata`=32'hA11C_0001, `pslverr`=0.
- Write 0x8 ← 32'hDEAD_BEEF, read 0x8 → `wr_pulse_o`=8'b0000_0100 for one cycle, read returns 32'hDEAD_BEEF, `regs_o[95:64]` matches.
- Write 0x4 ← 32'h1234, read 0x22, read 0x20 (NUM_REGS=8) → all three `pslverr`=1, `prdata`=0, no write pulse, reg contents unchanged.
- `status_i`=32'h0000_00A5 at setup, read 0x4 → `prdata`=32'h0000_00A5.
- Back-to-back write 0xC then read 0xC with WAIT_STATES=0 → each completes in 2 cycles, read returns written data.
- Drop `psel` mid-ACCESS on write to 0x10, and assert `preset` mid-ACCESS on write to 0x14 → no pulses, both regs remain 0, FSM accepts next setup.
